gppm_ctrl: RTL and testbench

GPPM_CTRL -- requirements
Module: gppm_ctrl

---
 rtl/gppm_ctrl_pkg.sv | 31 +++
 rtl/gppm_ctrl_decode.sv | 37 +++
 rtl/gppm_ctrl.sv | 118 +++++++++++
 tb/tb_gppm_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gppm_ctrl_pkg.sv
// Shared opcode values, instruction field positions and controller state encoding.
package gppm_ctrl_pkg;

    localparam logic [3:0] OpNop  = 4'h0;
    localparam logic [3:0] OpAlu  = 4'h1;
    localparam logic [3:0] OpLdi  = 4'h2;
    localparam logic [3:0] OpBz   = 4'h3;
    localparam logic [3:0] OpJmp  = 4'h4;
    localparam logic [3:0] OpCmp  = 4'h5;
    localparam logic [3:0] OpHalt = 4'hF;

    localparam int OpHi = 31;
    localparam int OpLo = 28;
    localparam int RdHi = 27;
    localparam int RdLo = 24;
    localparam int RaHi = 23;
    localparam int RaLo = 20;
    localparam int RbHi = 19;
    localparam int RbLo = 16;
    localparam int FnHi = 15;
    localparam int FnLo = 12;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StFetchk,
        StExec,
        StHalt
    } state_t;

endpackage

// File: rtl/gppm_ctrl_decode.sv
// Combinational field split and opcode class decode of the latched instruction word.
module gppm_ctrl_decode
    import gppm_ctrl_pkg::*;
#(
    parameter int IMEM_AW = 8
) (
    input  logic [31:0]        instr,
    output logic [3:0]         rd,
    output logic [3:0]         ra,
    output logic [3:0]         rb,
    output logic [3:0]         fn,
    output logic [IMEM_AW-1:0] tgt,
    output logic               is_write,
    output logic               is_alu,
    output logic               is_bz,
    output logic               is_jmp,
    output logic               is_halt
);

    logic [3:0] op;

    // Field extraction and opcode classification; unknown opcodes decode to nothing (NOP)
    always_comb begin
        op       = instr[OpHi:OpLo];
        rd       = instr[RdHi:RdLo];
        ra       = instr[RaHi:RaLo];
        rb       = instr[RbHi:RbLo];
        fn       = instr[FnHi:FnLo];
        tgt      = instr[IMEM_AW-1:0];
        is_alu   = (op == OpAlu);
        is_write = (op == OpAlu) || (op == OpLdi);
        is_bz    = (op == OpBz);
        is_jmp   = (op == OpJmp);
        is_halt  = (op == OpHalt);
    end

endmodule

// File: rtl/gppm_ctrl.sv
// GPPM sequencer: fetches 32-bit instructions, drives datapath register addresses,
// function and write controls, and resolves branches from the ALU zero flag.
module gppm_ctrl
    import gppm_ctrl_pkg::*;
#(
    parameter int IMEM_AW = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               imem_req,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic               imem_ack,
    input  logic [31:0]        imem_data,
    output logic [3:0]         raddr1,
    output logic [3:0]         raddr2,
    output logic [3:0]         waddr,
    output logic               wen,
    output logic               wdsrc,
    output logic [3:0]         func,
    output logic [31:0]        constant,
    input  logic               isZero
);

    state_t             state;
    logic [IMEM_AW-1:0] pc;
    logic [31:0]        instr;

    logic [IMEM_AW-1:0] tgt;
    logic               is_write;
    logic               is_alu;
    logic               is_bz;
    logic               is_jmp;
    logic               is_halt;

    gppm_ctrl_decode #(
        .IMEM_AW (IMEM_AW)
    ) u_decode (
        .instr    (instr),
        .rd       (waddr),
        .ra       (raddr1),
        .rb       (raddr2),
        .fn       (func),
        .tgt      (tgt),
        .is_write (is_write),
        .is_alu   (is_alu),
        .is_bz    (is_bz),
        .is_jmp   (is_jmp),
        .is_halt  (is_halt)
    );

    // Sequencer FSM: PC, instruction/constant latches and the done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= StIdle;
            pc       <= '0;
            instr    <= '0;
            constant <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                StIdle: begin
                    if (start) begin
                        state <= StFetch;
                        pc    <= '0;
                    end
                end
                StFetch: begin
                    if (imem_ack) begin
                        instr <= imem_data;
                        pc    <= pc + 1'b1;
                        state <= (imem_data[OpHi:OpLo] == OpLdi) ? StFetchk : StExec;
                    end
                end
                StFetchk: begin
                    if (imem_ack) begin
                        constant <= imem_data;
                        pc       <= pc + 1'b1;
                        state    <= StExec;
                    end
                end
                StExec: begin
                    // isZero reflects ra fn rb of the latched instruction this cycle
                    if (is_jmp || (is_bz && isZero)) begin
                        pc <= tgt;
                    end
                    if (is_halt) begin
                        state <= StHalt;
                        done  <= 1'b1;
                    end else begin
                        state <= StFetch;
                    end
                end
                StHalt: begin
                    if (start) begin
                        state <= StIdle;
                        pc    <= '0;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    // State-decoded handshake and write strobes; reset kills a write in the same cycle
    always_comb begin
        busy     = (state == StFetch) || (state == StFetchk) || (state == StExec);
        imem_req = (state == StFetch) || (state == StFetchk);
        wen      = (state == StExec) && is_write && !rst;
        wdsrc    = is_alu;
    end

    assign imem_addr = pc;

endmodule

// File: tb/tb_gppm_ctrl.sv
// Directed bench for gppm_ctrl with a behavioural instruction memory and ack delay.
module tb_gppm_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_data;
    logic [3:0]  raddr1, raddr2, waddr, func;
    logic        wen, wdsrc;
    logic [31:0] constant;
    logic        isZero = 1'b0;

    logic [31:0] mem [0:255];

    int errors = 0;
    int checks = 0;

    int ack_delay = 0;
    int wait_cnt = 0;
    logic spur = 1'b0;
    logic held = 1'b0;
    logic [7:0] held_addr = '0;
    int stable_err = 0;
    int req_cycles = 0;
    int done_cnt = 0;

    logic [7:0]  fetch_log [$];
    logic [3:0]  wen_waddr [$];
    logic [31:0] wen_const [$];
    logic        wen_src   [$];

    gppm_ctrl #(
        .IMEM_AW (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_data (imem_data),
        .raddr1    (raddr1),
        .raddr2    (raddr2),
        .waddr     (waddr),
        .wen       (wen),
        .wdsrc     (wdsrc),
        .func      (func),
        .constant  (constant),
        .isZero    (isZero)
    );

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr];

    // Memory responder (ack after ack_delay wait cycles) and activity logger
    always @(negedge clk) begin
        if (imem_ack) wait_cnt = 0;
        imem_ack = spur;
        if (imem_req) begin
            if (wait_cnt >= ack_delay) imem_ack = 1'b1;
            else wait_cnt++;
            req_cycles++;
            if (held && imem_addr != held_addr) stable_err++;
        end else begin
            wait_cnt = 0;
        end
        held      = imem_req && !imem_ack;
        held_addr = imem_addr;
        if (imem_req && imem_ack) fetch_log.push_back(imem_addr);
        if (wen) begin
            wen_waddr.push_back(waddr);
            wen_const.push_back(constant);
            wen_src.push_back(wdsrc);
        end
        if (done) done_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        fetch_log.delete();
        wen_waddr.delete();
        wen_const.delete();
        wen_src.delete();
        done_cnt   = 0;
        stable_err = 0;
        req_cycles = 0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            tick();
            n++;
        end
        chk("done_timeout", done_cnt != 0, 1);
    endtask

    task automatic load_p1();
        clear_mem();
        mem[0] = 32'h2100_0000;  // LDI r1
        mem[1] = 32'h0000_0005;
        mem[2] = 32'h2200_0000;  // LDI r2
        mem[3] = 32'h0000_0005;
        mem[4] = 32'h5012_1000;  // CMP r1 sub r2
        mem[5] = 32'hF000_0000;  // HALT
    endtask

    initial begin
        clear_mem();
        // Reset state
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_req", imem_req, 0);
        chk("rst_wen", wen, 0);
        chk("rst_done", done, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_waddr", waddr, 0);
        chk("rst_const", constant, 0);
        rst = 1'b0;
        clear_logs();

        // LDI/LDI/CMP/HALT with zero-wait ack
        load_p1();
        pulse_start();
        chk("p1_req0", imem_req, 1);
        chk("p1_addr0", imem_addr, 0);
        chk("p1_busy", busy, 1);
        tick();
        chk("p1_addr1", imem_addr, 1);
        chk("p1_fk_wen", wen, 0);
        tick();
        chk("p1_wen", wen, 1);
        chk("p1_waddr", waddr, 1);
        chk("p1_const", constant, 5);
        chk("p1_wdsrc", wdsrc, 0);
        wait_done(100);
        tick();
        chk("p1_done_pulse", done, 0);
        chk("p1_busy_after", busy, 0);
        chk("p1_wen_cnt", wen_waddr.size(), 2);
        chk("p1_waddr_a", wen_waddr[0], 1);
        chk("p1_waddr_b", wen_waddr[1], 2);
        chk("p1_const_a", wen_const[0], 5);
        chk("p1_const_b", wen_const[1], 5);
        chk("p1_done_cnt", done_cnt, 1);
        chk("p1_fetches", fetch_log.size(), 6);

        // HALT -> IDLE on start, no fetch until a further start
        pulse_start();
        chk("halt_idle_busy", busy, 0);
        tick();
        chk("halt_idle_req", imem_req, 0);

        // BZ not taken
        clear_mem();
        mem[0] = 32'h2100_0000;
        mem[1] = 32'h0000_0003;
        mem[2] = 32'h3011_0006;  // BZ r1 pass r1 -> 6
        mem[3] = 32'hF000_0000;
        mem[6] = 32'hF000_0000;
        clear_logs();
        pulse_start();
        wait_done(100);
        chk("bz_nt_cnt", fetch_log.size(), 4);
        chk("bz_nt_addr", fetch_log[3], 3);
        chk("bz_nt_const", wen_const[0], 3);

        // BZ taken
        do_reset();
        isZero = 1'b1;
        pulse_start();
        wait_done(100);
        chk("bz_t_cnt", fetch_log.size(), 4);
        chk("bz_t_addr", fetch_log[3], 6);
        isZero = 1'b0;

        // Four-cycle ack delay on every fetch
        do_reset();
        load_p1();
        ack_delay = 4;
        pulse_start();
        for (int k = 0; k < 4; k++) begin
            chk("dly_req", imem_req, 1);
            chk("dly_addr", imem_addr, 0);
            chk("dly_ack", imem_ack, 0);
            chk("dly_wen", wen, 0);
            tick();
        end
        chk("dly_ack5", imem_ack, 1);
        wait_done(300);
        chk("dly_stable", stable_err, 0);
        chk("dly_req_cycles", req_cycles, 30);
        chk("dly_wen_cnt", wen_waddr.size(), 2);
        chk("dly_waddr_b", wen_waddr[1], 2);
        chk("dly_const_b", wen_const[1], 5);
        ack_delay = 0;

        // Reset during EXEC of an ALU instruction
        do_reset();
        clear_mem();
        mem[0] = 32'h1312_2000;  // ALU r3 = r1 fn2 r2
        mem[1] = 32'hF000_0000;
        pulse_start();
        tick();
        chk("alu_wen", wen, 1);
        chk("alu_wdsrc", wdsrc, 1);
        chk("alu_waddr", waddr, 3);
        chk("alu_raddr1", raddr1, 1);
        chk("alu_raddr2", raddr2, 2);
        chk("alu_func", func, 2);
        rst = 1'b1;
        #1;
        chk("exec_rst_wen", wen, 0);
        tick();
        chk("exec_rst_busy", busy, 0);
        chk("exec_rst_pc", imem_addr, 0);
        chk("exec_rst_waddr", waddr, 0);
        chk("exec_rst_req", imem_req, 0);
        rst = 1'b0;

        // JMP to last word, PC wraps to 0
        do_reset();
        clear_mem();
        mem[0]   = 32'h4000_00FF;
        mem[255] = 32'h0000_0000;
        pulse_start();
        repeat (8) tick();
        chk("wrap_cnt_ok", fetch_log.size() >= 3, 1);
        chk("wrap_f1", fetch_log[1], 255);
        chk("wrap_f2", fetch_log[2], 0);

        // Spurious ack while idle, start while busy, unknown opcode
        do_reset();
        clear_mem();
        mem[0] = 32'h7300_0000;  // opcode 7 acts as NOP
        mem[1] = 32'h0000_0000;
        mem[2] = 32'h1412_0000;  // ALU r4
        mem[3] = 32'hF000_0000;
        spur = 1'b1;
        tick();
        spur = 1'b0;
        tick();
        chk("spur_busy", busy, 0);
        chk("spur_waddr", waddr, 0);
        clear_logs();
        pulse_start();
        tick();
        chk("op7_wen", wen, 0);
        chk("op7_busy", busy, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_start_pc", imem_addr, 1);
        wait_done(100);
        chk("op7_fetches", fetch_log.size(), 4);
        chk("op7_f3", fetch_log[3], 3);
        chk("op7_wen_cnt", wen_waddr.size(), 1);
        chk("op7_waddr", wen_waddr[0], 4);
        chk("op7_wdsrc", wen_src[0], 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
